sensor_frame_packer: RTL
========================

# sensor_frame_packer

Upstream feeder for `algo_top`: collects one sensor frame of 32-bit samples from the acquisition front end and emits it as one Avalon-ST packet (SOP on first word, EOP on last, `empty` = 0) on a zero-latency source interface. A show-ahead FIFO absorbs backpressure from `algo_top`. Frames are admitted whole or dropped whole, so downstream packets are always exactly the configured length.

## Interface
- `WORDS_PER_PKT`, 163: sample words per frame/packet.
- `FIFO_DEPTH`, 512: FIFO entries; power of two, ≥ 2×packet length.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `frame_start`  in  1: one-cycle pulse marking the start of a sensor frame.
- `sample_data`  in  32: sample word.
- `sample_valid`  in  1: `sample_data` qualifier; no backpressure toward the front end.
- `data_out_data`  out  32: Avalon-ST data.
- `data_out_valid`  out  1: Avalon-ST valid.
- `data_out_ready`  in  1: Avalon-ST ready (readyLatency 0).
- `data_out_startofpacket`  out  1: SOP.
- `data_out_endofpacket`  out  1: EOP.
- `data_out_empty`  out  2: constant 0.
- `frames_sent`  out  16: frames admitted, wraps at 2^16.
- `frames_dropped`  out  16: frames rejected for lack of space, saturates at 0xFFFF.
- `seq_err`  out  1: sticky; set on `frame_start` while collecting.

## Operation
- `L` = packet length = `WORDS_PER_PKT`, or `WORDS_PER_PKT`+1 with `FRAME_HEADER_EN`.
- FIFO entry = {sop, eop, data[31:0]}, 34 bits.
- Write-side FSM:
  - IDLE: on `frame_start`, admit the frame if FIFO free entries ≥ `L`: go to COLLECT, clear the word counter, and increment `frames_sent`. Otherwise stay in IDLE, increment `frames_dropped` (saturating), and ignore the frame's samples.
  - COLLECT: each `sample_valid` writes one entry and increments the word counter. The first packet word carries sop=1. Word `L-1` carries eop=1 and returns the FSM to IDLE.
  - `frame_start` in COLLECT is ignored, sets `seq_err`, and does not restart the frame.
  - `sample_valid` in IDLE is discarded.
- The admission check guarantees the FIFO never overflows. No full-write case exists.
- `frame_start` and `sample_valid` in the same cycle while in IDLE: the frame is admitted, and that sample is not written. Data starts on the next `sample_valid`.
- Read side:
  - `data_out_valid` = FIFO not empty.
  - Outputs show the head entry.
  - Pop on `valid && ready`.
  - Outputs are stable while `valid && !ready`.
- Simultaneous push and pop are allowed at any fill level, including empty and full−1.
- Free-space computation counts a pop occurring in the admission cycle as not yet freed (conservative).
- Reset values:
  - all counters 0, `seq_err` 0, FIFO empty, FSM IDLE
  - `data_out_valid`, `data_out_startofpacket`, `data_out_endofpacket` all 0
  - `data_out_data` 0, `data_out_empty` 0
- Reset mid-frame discards the FIFO contents. `algo_top` sees a truncated packet only if reset is not shared.

## Timing
- A word written at edge k is visible with `data_out_valid`=1 after edge k, and is poppable at edge k+1 (one-cycle latency when the FIFO is empty).
- Sustained throughput: one word per cycle in and out.
- Counter and `seq_err` updates are visible the cycle after the triggering edge.

## Configuration
- `SENSOR_FRAME_HEADER_EN` defined:
  - On admission, a header entry is written in the same cycle: {sop=1, data = 0xA5, `frames_sent`[15:0] pre-increment, 8'h00}.
  - The first sample carries sop=0.
  - Packet length is `WORDS_PER_PKT`+1.
  - EOP is on the last sample.
- Macro undefined: no header. The first sample carries SOP, and packet length is `WORDS_PER_PKT`.

## Structure
- Shared package `sensor_pkg`:
  - `WORDS_PER_PKT` default
  - header magic 0xA5
  - FIFO entry typedef (sop, eop, data)
  - FSM state enum {IDLE, COLLECT}
- Sub-module `sfp_fifo`: synchronous show-ahead FIFO with `fill` count output.
- Top level holds the FSM, the counters and the header mux.

## Test plan
- Reset, one frame of 163 words 0x000927C1..0x00092863, `ready`=1 → one packet of 163 words in order; SOP on 0x000927C1 only, EOP on 0x00092863 only; `frames_sent`=1.
- Same frame with `ready` toggling 1/0 every cycle → identical word sequence; no data change while `valid && !ready`.
- `ready`=0 and 4 frames sent back-to-back → frames 1–3 stored (489 entries); frame 4 dropped (free space 23 < 163); `frames_dropped`=1. After `ready`=1, exactly 3 packets are output.
- `frame_start` pulsed at sample 50 of a frame → `seq_err`=1; the packet is still 163 words with EOP on the original word 163.
- `rst` low during word 80 with `ready`=0 → all outputs return to their reset values, `valid`=0. The next frame is output cleanly.
- `SENSOR_FRAME_HEADER_EN` defined, 2 frames → packets of 164 words; header words 0xA5000000 and 0xA5000100; SOP on the header, EOP on the last sample.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor frame packer: FIFO entry layout,
// write-side FSM states and the optional frame header format.
package sensor_pkg;

  localparam int WORDS_PER_PKT_DEFAULT = 163;
  localparam logic [7:0] HEADER_MAGIC = 8'hA5;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } wr_state_e;

  // Header word: magic, 16-bit frame sequence number, zero pad byte.
  function automatic fifo_entry_t make_header(input logic [15:0] seq);
    fifo_entry_t e;
    e.sop  = 1'b1;
    e.eop  = 1'b0;
    e.data = {HEADER_MAGIC, seq, 8'h00};
    return e;
  endfunction

endpackage

// File: rtl/sfp_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible whenever the FIFO is not
// empty, and pop advances to the next entry. Push and pop may coincide at any level.
module sfp_fifo
  import sensor_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fifo_entry_t              push_entry,
  input  logic                     pop,
  output fifo_entry_t              head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          pop_ok;

  assign pop_ok = pop && (fill_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    fill_d   = fill_q + FW'(push) - FW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

  assign head  = mem[rd_ptr_q];
  assign empty = (fill_q == '0);
  assign fill  = fill_q;

endmodule

// File: rtl/sensor_frame_packer.sv
// Packs sensor frames into Avalon-ST packets; whole frames are admitted or dropped.
// Optional header word per packet when SENSOR_FRAME_HEADER_EN is defined.
module sensor_frame_packer
  import sensor_pkg::*;
#(
  parameter int WORDS_PER_PKT = WORDS_PER_PKT_DEFAULT,
  parameter int FIFO_DEPTH    = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [31:0] sample_data,
  input  logic        sample_valid,
  output logic [31:0] data_out_data,
  output logic        data_out_valid,
  input  logic        data_out_ready,
  output logic        data_out_startofpacket,
  output logic        data_out_endofpacket,
  output logic [1:0]  data_out_empty,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_dropped,
  output logic        seq_err
);

`ifdef SENSOR_FRAME_HEADER_EN
  localparam int PKT_LEN = WORDS_PER_PKT + 1;
`else
  localparam int PKT_LEN = WORDS_PER_PKT;
`endif
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W  = $clog2(WORDS_PER_PKT + 1);

  wr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [15:0]        frames_sent_q, frames_sent_d;
  logic [15:0]        frames_dropped_q, frames_dropped_d;
  logic               seq_err_q, seq_err_d;

  logic               push;
  fifo_entry_t        push_entry;
  fifo_entry_t        head;
  logic               fifo_empty;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  free_entries;
  logic               admit;

  // Fill is sampled before any same-cycle pop, so admission is conservative.
  assign free_entries = FILL_W'(FIFO_DEPTH) - fill;
  assign admit        = (free_entries >= FILL_W'(PKT_LEN));

  always_comb begin
    state_d          = state_q;
    word_cnt_d       = word_cnt_q;
    frames_sent_d    = frames_sent_q;
    frames_dropped_d = frames_dropped_q;
    seq_err_d        = seq_err_q;
    push             = 1'b0;
    push_entry       = '0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          if (admit) begin
            state_d       = COLLECT;
            word_cnt_d    = '0;
            frames_sent_d = frames_sent_q + 16'd1;
`ifdef SENSOR_FRAME_HEADER_EN
            push          = 1'b1;
            push_entry    = make_header(frames_sent_q);
`endif
          end else if (frames_dropped_q != 16'hFFFF) begin
            frames_dropped_d = frames_dropped_q + 16'd1;
          end
        end
      end
      COLLECT: begin
        if (frame_start) begin
          seq_err_d = 1'b1;
        end
        if (sample_valid) begin
          push            = 1'b1;
          push_entry.data = sample_data;
`ifdef SENSOR_FRAME_HEADER_EN
          push_entry.sop  = 1'b0;
`else
          push_entry.sop  = (word_cnt_q == '0);
`endif
          push_entry.eop  = (word_cnt_q == CNT_W'(WORDS_PER_PKT - 1));
          word_cnt_d      = word_cnt_q + CNT_W'(1);
          if (push_entry.eop) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      word_cnt_q       <= '0;
      frames_sent_q    <= '0;
      frames_dropped_q <= '0;
      seq_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_cnt_q       <= word_cnt_d;
      frames_sent_q    <= frames_sent_d;
      frames_dropped_q <= frames_dropped_d;
      seq_err_q        <= seq_err_d;
    end
  end

  sfp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (data_out_ready),
    .head       (head),
    .empty      (fifo_empty),
    .fill       (fill)
  );

  // Outputs are forced to zero while empty so stale storage never leaks out.
  assign data_out_valid         = !fifo_empty;
  assign data_out_data          = fifo_empty ? 32'h0 : head.data;
  assign data_out_startofpacket = !fifo_empty && head.sop;
  assign data_out_endofpacket   = !fifo_empty && head.eop;
  assign data_out_empty         = 2'b00;
  assign frames_sent            = frames_sent_q;
  assign frames_dropped         = frames_dropped_q;
  assign seq_err                = seq_err_q;

endmodule
